isp_debayer_seq: RTL and testbench
==================================

# isp_debayer_seq

Frame sequencer that feeds the Bayer demosaic stage from the SDRAM read-side raw FIFO. Consumes a valid/ready raw pixel stream and regenerates clean `vsync`/`href`/`de` timing with programmable blanking. Latches the Bayer pattern selection once per frame so a mid-frame register write never tears an image. Reports underflow and frame-sync errors, and optionally appends flush lines so the demosaic line buffer emits the final image row.

## Interface
Parameters:
- `BITS`, 8, raw pixel width
- `WIDTH`, 1280, active pixels per line
- `HEIGHT`, 960, active lines per frame
- `HBLANK`, 160, blank cycles after each line (>=2)
- `VSYNC_LINES`, 2, line periods with vsync high
- `VBP_LINES`, 4, line periods between vsync fall and first active line

Ports (one clock; reset is synchronous and active-high):
- `pclk` in 1 — pixel clock
- `rst` in 1 — synchronous active-high reset
- `cfg_enable` in 1 — run frames continuously while high
- `cfg_bayer` in 2 — 0:RGGB 1:GRBG 2:GBRG 3:BGGR
- `s_valid` in 1 — raw pixel valid
- `s_ready` out 1 — pixel accepted when `s_valid & s_ready`
- `s_data` in BITS — raw pixel
- `s_sof` in 1 — marks first pixel of a frame
- `out_vsync`, `out_href`, `out_de` out 1 — timing to demosaic
- `out_raw` out BITS — raw pixel to demosaic
- `out_bayer` out 2 — frame-latched pattern
- `frame_done` out 1 — one-cycle pulse at end of frame
- `underflow` out 1 — sticky: active cycle without `s_valid`
- `sync_err` out 1 — sticky: `s_sof` misplaced or missing

## Operation
- States: IDLE, VS, VBP, ACT, HBL, FLUSH, DONE.
- Line period is `WIDTH+HBLANK` cycles in every state except IDLE and DONE. `hcnt` counts 0..WIDTH+HBLANK-1; `vcnt` counts line periods within a state group.
- IDLE: outputs low. When `cfg_enable`=1, latch `cfg_bayer` into `out_bayer` and go to VS.
- VS: `out_vsync`=1 for VSYNC_LINES periods, then VBP.
- VBP: all timing low for VBP_LINES periods, then ACT.
- ACT: `out_href`=`out_de`=1 and `s_ready`=1 for WIDTH cycles, then HBL.
- HBL: HBLANK cycles with `href` low.
  - If fewer than HEIGHT active lines are done, return to ACT.
  - Otherwise go to FLUSH (macro on) or DONE.
- DONE: pulse `frame_done` for one cycle.
  - If `cfg_enable`=1: latch `cfg_bayer` and go to VS.
  - Otherwise go to IDLE.
- Pixel path in ACT:
  - If `s_valid`=1, `out_raw` = `s_data`.
  - If `s_valid`=0, `out_raw` = 0, `underflow` is set, and timing proceeds unchanged. The geometry never stretches.
- `s_ready`=0 outside ACT. Upstream holds its data.
- `sync_err` is set when:
  - `s_sof` is accepted at any position other than line 0 / pixel 0, or
  - pixel 0 of line 0 is accepted without `s_sof`.
- `cfg_enable` falling mid-frame: the current frame completes, then the block enters IDLE.
- `cfg_bayer` changes mid-frame: `out_bayer` does not change until the next latch point.
- `underflow` and `sync_err` clear only on `rst` or when leaving IDLE.

## Timing
- Reset value of every output is 0: `s_ready`, `out_vsync`, `out_href`, `out_de`, `out_raw`, `out_bayer`, `frame_done`, `underflow`, `sync_err`.
- `rst` mid-frame forces IDLE on the next edge. Counters are zeroed.
- All outputs except `s_ready` are registered, one cycle after the state/counter decision. `s_ready` is combinational from state.
- A pixel accepted at edge n appears on `out_raw` after edge n+1, aligned with its `out_href`/`out_de`.
- First `out_vsync` rises 1 cycle after the IDLE→VS transition. First `out_href` rises `(VSYNC_LINES+VBP_LINES)*(WIDTH+HBLANK)+1` cycles after that transition.
- Counter widths: `hcnt` is `$clog2(WIDTH+HBLANK)`; `vcnt` is `$clog2(HEIGHT+VSYNC_LINES+VBP_LINES+2)`. Terminal counts use compare-equal only; no wrap beyond the terminal count.
- Simultaneous `s_sof` and underflow on the same cycle: both stickies are evaluated independently, with no priority between them.

## Configuration
- Macro `ISP_DEBAYER_SEQ_FLUSH_EN`.
- Defined:
  - After the last HBL, FLUSH emits 2 line periods.
  - Each has `out_href`=1 for WIDTH cycles, `out_de`=0, `out_raw`=0, `s_ready`=0, followed by HBLANK.
  - This drains the demosaic 1-line latency.
- Undefined: FLUSH is unreachable; HBL goes directly to DONE.

## Test plan
- WIDTH=8, HEIGHT=4, HBLANK=4, VSYNC_LINES=1, VBP_LINES=1, continuous `s_valid`, ramp data 0..31 with `s_sof` on 0 → 4 href pulses of 8, `out_raw` = ramp delayed 1 cycle, `frame_done` one pulse, no sticky flags.
- Same geometry, drop `s_valid` for pixel 3 of line 1 → `out_raw`=0 in that slot, `underflow`=1 held, later pixels on time, frame length unchanged.
- `s_sof` on pixel 5 of line 0 → `sync_err`=1. Next frame with correct `s_sof`: flag still 1 until IDLE exit or `rst`.
- Change `cfg_bayer` 0→3 mid-frame with `cfg_enable`=1 → `out_bayer` stays 0 through `frame_done`, reads 3 from the next VS.
- Drop `cfg_enable` in line 2 → frame completes, IDLE, `s_ready` stays 0. Assert `rst` during ACT on a second run → all outputs 0 next cycle.
- With `ISP_DEBAYER_SEQ_FLUSH_EN` defined → 6 href pulses, last 2 with `de`=0 and `out_raw`=0. Undefined → exactly 4 href pulses.

Source files
------------

// File: rtl/isp_debayer_seq.sv
// isp_debayer_seq: frame sequencer between the SDRAM raw read FIFO and the demosaic.
// Turns a valid/ready raw pixel stream into a clean vsync/href/de frame with
// programmable blanking. The Bayer pattern is latched once per frame.
//
// Optional feature macro: ISP_DEBAYER_SEQ_FLUSH_EN. When defined, two flush line
// periods (href high, de low, raw zero) follow the last active line so the
// demosaic line buffer releases its final row.
//
// Ports:
//   pclk, rst        pixel clock, synchronous active-high reset
//   cfg_enable       run frames back-to-back while high
//   cfg_bayer        0:RGGB 1:GRBG 2:GBRG 3:BGGR, latched at VS entry
//   s_valid/s_ready  raw pixel handshake (s_ready combinational, high in ACT only)
//   s_data, s_sof    raw pixel and start-of-frame marker
//   out_vsync/href/de, out_raw, out_bayer   registered timing and pixel to demosaic
//   frame_done       one-cycle pulse at end of frame
//   underflow        sticky: ACT cycle without s_valid
//   sync_err         sticky: s_sof misplaced or missing
module isp_debayer_seq #(
  parameter int unsigned BITS        = 8,
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 960,
  parameter int unsigned HBLANK      = 160,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned VBP_LINES   = 4
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            cfg_enable,
  input  logic [1:0]      cfg_bayer,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  input  logic            s_sof,
  output logic            out_vsync,
  output logic            out_href,
  output logic            out_de,
  output logic [BITS-1:0] out_raw,
  output logic [1:0]      out_bayer,
  output logic            frame_done,
  output logic            underflow,
  output logic            sync_err
);

  localparam int unsigned LineLen = WIDTH + HBLANK;
  localparam int unsigned HW      = $clog2(LineLen);
  localparam int unsigned VW      = $clog2(HEIGHT + VSYNC_LINES + VBP_LINES + 2);

  localparam logic [HW-1:0] HLast    = HW'(LineLen - 1);
  localparam logic [HW-1:0] HActLast = HW'(WIDTH - 1);
  localparam logic [HW-1:0] HWidth   = HW'(WIDTH);
  localparam logic [VW-1:0] VsLast   = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VbpLast  = VW'(VBP_LINES - 1);
  localparam logic [VW-1:0] ActLast  = VW'(HEIGHT - 1);
  localparam logic [VW-1:0] FlushLast = VW'(1);

  typedef enum logic [2:0] {StIdle, StVs, StVbp, StAct, StHbl, StFlush, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [HW-1:0]   r_hcnt, w_hcnt_nxt;
  logic [VW-1:0]   r_vcnt, w_vcnt_nxt;
  logic            w_latch;
  logic            w_leave_idle;
  logic            w_accept;
  logic            w_first;

  logic            r_vsync, r_href, r_de, r_frame_done, r_underflow, r_sync_err;
  logic [BITS-1:0] r_raw;
  logic [1:0]      r_bayer;

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_latch     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cfg_enable) begin
          w_state_nxt = StVs;
          w_latch     = 1'b1;
          w_hcnt_nxt  = '0;
          w_vcnt_nxt  = '0;
        end
      end
      StVs: begin
        if (r_hcnt == HLast) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == VsLast) begin
            w_state_nxt = StVbp;
            w_vcnt_nxt  = '0;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      StVbp: begin
        if (r_hcnt == HLast) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == VbpLast) begin
            w_state_nxt = StAct;
            w_vcnt_nxt  = '0;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      StAct: begin
        // hcnt keeps running through HBL so the line period stays fixed.
        w_hcnt_nxt = r_hcnt + 1'b1;
        if (r_hcnt == HActLast) w_state_nxt = StHbl;
      end
      StHbl: begin
        if (r_hcnt == HLast) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == ActLast) begin
            w_vcnt_nxt = '0;
`ifdef ISP_DEBAYER_SEQ_FLUSH_EN
            w_state_nxt = StFlush;
`else
            w_state_nxt = StDone;
`endif
          end else begin
            w_vcnt_nxt  = r_vcnt + 1'b1;
            w_state_nxt = StAct;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      StFlush: begin
        if (r_hcnt == HLast) begin
          w_hcnt_nxt = '0;
          if (r_vcnt == FlushLast) begin
            w_state_nxt = StDone;
            w_vcnt_nxt  = '0;
          end else begin
            w_vcnt_nxt = r_vcnt + 1'b1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      StDone: begin
        w_hcnt_nxt = '0;
        w_vcnt_nxt = '0;
        if (cfg_enable) begin
          w_state_nxt = StVs;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign s_ready      = (r_state == StAct);
  assign w_accept     = s_ready & s_valid;
  assign w_first      = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_leave_idle = (r_state == StIdle) && cfg_enable;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_de         <= 1'b0;
      r_raw        <= '0;
      r_bayer      <= 2'd0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_vsync      <= (r_state == StVs);
      r_href       <= (r_state == StAct) || ((r_state == StFlush) && (r_hcnt < HWidth));
      r_de         <= (r_state == StAct);
      // Missing pixels go out as zero; geometry never stretches.
      r_raw        <= w_accept ? s_data : '0;
      r_frame_done <= (r_state == StDone);
      if (w_latch) r_bayer <= cfg_bayer;
      if (w_leave_idle) begin
        r_underflow <= 1'b0;
        r_sync_err  <= 1'b0;
      end else begin
        // Independent stickies: no priority between underflow and sync error.
        if (s_ready && !s_valid) r_underflow <= 1'b1;
        if (w_accept && (s_sof != w_first)) r_sync_err <= 1'b1;
      end
    end
  end

  assign out_vsync  = r_vsync;
  assign out_href   = r_href;
  assign out_de     = r_de;
  assign out_raw    = r_raw;
  assign out_bayer  = r_bayer;
  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_isp_debayer_seq.sv
// Directed bench for isp_debayer_seq with an 8x4 frame, HBLANK=4, one vsync line
// and one back-porch line (line period 12 cycles).
module tb_isp_debayer_seq;

  localparam int unsigned BITS = 8;
`ifdef ISP_DEBAYER_SEQ_FLUSH_EN
  localparam int NHref = 6;
  localparam int FdLen = 96;
`else
  localparam int NHref = 4;
  localparam int FdLen = 72;
`endif

  logic            pclk = 1'b0;
  logic            rst;
  logic            cfg_enable;
  logic [1:0]      cfg_bayer;
  logic            s_valid;
  logic            s_ready;
  logic [BITS-1:0] s_data;
  logic            s_sof;
  logic            out_vsync, out_href, out_de;
  logic [BITS-1:0] out_raw;
  logic [1:0]      out_bayer;
  logic            frame_done, underflow, sync_err;

  int vectors     = 0;
  int miscompares = 0;

  // Per-frame observations.
  int f_vs, f_href1, f_fd, f_hrefs, f_des, f_bayer_bad;

  isp_debayer_seq #(
    .BITS(BITS), .WIDTH(8), .HEIGHT(4), .HBLANK(4), .VSYNC_LINES(1), .VBP_LINES(1)
  ) dut (
    .pclk(pclk), .rst(rst), .cfg_enable(cfg_enable), .cfg_bayer(cfg_bayer),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .out_vsync(out_vsync), .out_href(out_href), .out_de(out_de), .out_raw(out_raw),
    .out_bayer(out_bayer), .frame_done(frame_done), .underflow(underflow),
    .sync_err(sync_err)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int slot, input int drop_slot, input int sof_slot);
    s_data  = BITS'(slot);
    s_valid = (slot != drop_slot);
    s_sof   = (slot == sof_slot);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, s_ready}, 0);
    chk({tag, "_vsync"}, {31'd0, out_vsync}, 0);
    chk({tag, "_href"}, {31'd0, out_href}, 0);
    chk({tag, "_de"}, {31'd0, out_de}, 0);
    chk({tag, "_raw"}, {24'd0, out_raw}, 0);
    chk({tag, "_bayer"}, {30'd0, out_bayer}, 0);
    chk({tag, "_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_uflow"}, {31'd0, underflow}, 0);
    chk({tag, "_syncerr"}, {31'd0, sync_err}, 0);
  endtask

  // Acts as upstream for one frame: slot k carries data k (slot advances on every
  // s_ready cycle). Checks de alignment and raw values cycle by cycle.
  task automatic run_frame(input int drop_slot, input int sof_slot, input int bayer_cyc,
                           input int en_cyc, input logic [1:0] bayer_exp);
    int slot;
    logic pend;
    logic prev_href;
    logic [BITS-1:0] pend_raw;
    slot = 0;
    prev_href = 1'b0;
    f_vs = 0; f_href1 = 0; f_fd = 0; f_hrefs = 0; f_des = 0; f_bayer_bad = 0;
    drive(slot, drop_slot, sof_slot);
    for (int c = 1; c <= 200; c++) begin
      pend     = s_ready;
      pend_raw = s_valid ? s_data : '0;
      if (s_ready) slot++;
      step();
      if (out_vsync && f_vs == 0) f_vs = c;
      if (out_href && !prev_href) begin
        f_hrefs++;
        if (f_href1 == 0) f_href1 = c;
      end
      prev_href = out_href;
      chk("de_align", {31'd0, out_de}, {31'd0, pend});
      if (out_de) begin
        f_des++;
        chk("raw_pix", {24'd0, out_raw}, {24'd0, pend_raw});
      end else if (out_href) begin
        chk("flush_raw", {24'd0, out_raw}, 0);
      end
      if (frame_done) begin
        f_fd = c;
        break;
      end
      if (out_bayer !== bayer_exp) f_bayer_bad++;
      if (c == bayer_cyc) cfg_bayer = 2'd3;
      if (c == en_cyc) cfg_enable = 1'b0;
      drive(slot, drop_slot, sof_slot);
    end
  endtask

  initial begin
    int bad;
    int seen;
    rst = 1'b1; cfg_enable = 1'b0; cfg_bayer = 2'd0;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
    step(); step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Frame A: clean frame from IDLE.
    cfg_enable = 1'b1;
    run_frame(-1, 0, -1, -1, 2'd0);
    chk("A_vs_first", f_vs, 2);
    chk("A_href_lat", f_href1 - f_vs, 24);
    chk("A_fd_len", f_fd - f_vs, FdLen);
    chk("A_hrefs", f_hrefs, NHref);
    chk("A_des", f_des, 32);
    chk("A_bayer", f_bayer_bad, 0);
    chk("A_uflow", {31'd0, underflow}, 0);
    chk("A_syncerr", {31'd0, sync_err}, 0);

    // Frame B: slot 11 (line 1, pixel 3) missing.
    run_frame(11, 0, -1, -1, 2'd0);
    chk("B_fd_len", f_fd - f_vs, FdLen);
    chk("B_des", f_des, 32);
    chk("B_uflow", {31'd0, underflow}, 1);
    chk("B_syncerr", {31'd0, sync_err}, 0);

    // Frame C: s_sof on pixel 5 of line 0 instead of pixel 0.
    run_frame(-1, 5, -1, -1, 2'd0);
    chk("C_syncerr", {31'd0, sync_err}, 1);
    chk("C_uflow_held", {31'd0, underflow}, 1);

    // Frame D: correct s_sof, cfg_bayer 0->3 mid-frame.
    run_frame(-1, 0, 40, -1, 2'd0);
    chk("D_syncerr_held", {31'd0, sync_err}, 1);
    chk("D_bayer_stable", f_bayer_bad, 0);
    chk("D_fd_len", f_fd - f_vs, FdLen);

    // Frame E: new pattern visible from VS; cfg_enable drops in active line 2.
    run_frame(-1, 0, -1, 50, 2'd3);
    chk("E_bayer_vs", f_bayer_bad, 0);
    chk("E_fd_len", f_fd - f_vs, FdLen);
    chk("E_hrefs", f_hrefs, NHref);

    // IDLE: nothing moves, stickies hold.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_ready !== 1'b0 || out_vsync !== 1'b0 || out_href !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_syncerr", {31'd0, sync_err}, 1);
    chk("idle_uflow", {31'd0, underflow}, 1);

    // Frame F: leaving IDLE clears stickies; reset lands during ACT.
    cfg_enable = 1'b1;
    step();
    chk("F_uflow_clr", {31'd0, underflow}, 0);
    chk("F_syncerr_clr", {31'd0, sync_err}, 0);
    s_valid = 1'b1; s_data = 8'hA5; s_sof = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_de) begin
        seen = 1;
        break;
      end
    end
    chk("F_de_seen", seen, 1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    cfg_enable = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
